// File: rtl/tl_c_release_sink.sv
// tl_c_release_sink: manager-side TileLink channel C responder for hart 0.
// Streams C data beats to a write port, pulses probe completions, answers releases with ReleaseAck.
`default_nettype none

module tl_c_release_sink #(
    parameter int ADDR_W      = 32,
    parameter int SRC_W       = 3,
    parameter int SIZE_W      = 4,
    parameter int LG_MAX_SIZE = 6,
    parameter int SINK_ID     = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [2:0]        c_opcode,
    input  logic [2:0]        c_param,
    input  logic [SIZE_W-1:0] c_size,
    input  logic [SRC_W-1:0]  c_source,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [63:0]       c_data,
    input  logic              c_corrupt,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [63:0]       wb_data,
    output logic              wb_last,
    output logic              wb_corrupt,
    output logic              pack_valid,
    output logic [SRC_W-1:0]  pack_source,
    output logic [2:0]        pack_param,
    output logic              pack_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [2:0]        d_param,
    output logic [SIZE_W-1:0] d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic [2:0]        d_sink,
    output logic              err_illegal
);

    localparam int CNT_W = LG_MAX_SIZE - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    last_q, last_d;
    logic [2:0]          op_q, op_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [2:0]          param_q, param_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cor_q, cor_d;
    logic                pack_valid_q, pack_valid_d;
    logic [SRC_W-1:0]    pack_src_q, pack_src_d;
    logic [2:0]          pack_param_q, pack_param_d;
    logic                pack_cor_q, pack_cor_d;
    logic                d_valid_q, d_valid_d;
    logic [SIZE_W-1:0]   d_size_q, d_size_d;
    logic [SRC_W-1:0]    d_src_q, d_src_d;
    logic                err_q, err_d;

    logic                hdr_legal;
    logic [CNT_W-1:0]    hdr_last;
    logic                fin;
    logic [2:0]          fin_op;
    logic [SIZE_W-1:0]   fin_size;
    logic [SRC_W-1:0]    fin_src;
    logic [2:0]          fin_param;
    logic                fin_cor;

    // Index of the final beat: 0 for sizes up to one beat, else 2^(size-3)-1.
    function automatic logic [CNT_W-1:0] last_idx(input logic [SIZE_W-1:0] sz);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (sz <= SIZE_W'(3)) return '0;
        return (one << (sz - SIZE_W'(3))) - one;
    endfunction

    assign hdr_legal = c_opcode[2] && (c_size <= SIZE_W'(LG_MAX_SIZE));
    assign hdr_last  = c_opcode[0] ? last_idx(c_size) : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        op_d         = op_q;
        size_d       = size_q;
        src_d        = src_q;
        param_d      = param_q;
        addr_d       = addr_q;
        cor_d        = cor_q;
        pack_valid_d = 1'b0;
        pack_src_d   = pack_src_q;
        pack_param_d = pack_param_q;
        pack_cor_d   = pack_cor_q;
        d_valid_d    = d_valid_q;
        d_size_d     = d_size_q;
        d_src_d      = d_src_q;
        err_d        = err_q;
        c_ready      = 1'b0;
        wb_valid     = 1'b0;
        wb_last      = 1'b0;
        fin          = 1'b0;
        fin_op       = c_opcode;
        fin_size     = c_size;
        fin_src      = c_source;
        fin_param    = c_param;
        fin_cor      = c_corrupt;

        case (state_q)
            ST_IDLE: begin
                if (!hdr_legal) begin
                    // Illegal headers are swallowed so the sender never deadlocks.
                    c_ready = 1'b1;
                    if (c_valid) err_d = 1'b1;
                end else if (c_opcode[0]) begin
                    wb_valid = c_valid;
                    c_ready  = wb_ready;
                    wb_last  = (hdr_last == '0);
                end else begin
                    c_ready = 1'b1;
                end
                if (c_valid && c_ready && hdr_legal) begin
                    op_d    = c_opcode;
                    size_d  = c_size;
                    src_d   = c_source;
                    param_d = c_param;
                    addr_d  = c_address;
                    last_d  = hdr_last;
                    cor_d   = c_corrupt;
                    cnt_d   = CNT_W'(1);
                    if (hdr_last == '0) fin = 1'b1;
                    else                state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wb_valid  = c_valid;
                c_ready   = wb_ready;
                wb_last   = (cnt_q == last_q);
                fin_op    = op_q;
                fin_size  = size_q;
                fin_src   = src_q;
                fin_param = param_q;
                fin_cor   = cor_q | c_corrupt;
                if (c_valid && wb_ready) begin
                    if ((c_opcode != op_q) || (c_source != src_q)) err_d = 1'b1;
                    cor_d = cor_q | c_corrupt;
                    cnt_d = cnt_q + CNT_W'(1);
                    fin   = wb_last;
                end
            end
            ST_ACK: begin
                if (d_ready) begin
                    d_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            if (fin_op[1]) begin
                d_valid_d = 1'b1;
                d_size_d  = fin_size;
                d_src_d   = fin_src;
                state_d   = ST_ACK;
            end else begin
                pack_valid_d = 1'b1;
                pack_src_d   = fin_src;
                pack_param_d = fin_param;
                pack_cor_d   = fin_cor;
                state_d      = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            op_q         <= '0;
            size_q       <= '0;
            src_q        <= '0;
            param_q      <= '0;
            addr_q       <= '0;
            cor_q        <= 1'b0;
            pack_valid_q <= 1'b0;
            pack_src_q   <= '0;
            pack_param_q <= '0;
            pack_cor_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            d_size_q     <= '0;
            d_src_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            op_q         <= op_d;
            size_q       <= size_d;
            src_q        <= src_d;
            param_q      <= param_d;
            addr_q       <= addr_d;
            cor_q        <= cor_d;
            pack_valid_q <= pack_valid_d;
            pack_src_q   <= pack_src_d;
            pack_param_q <= pack_param_d;
            pack_cor_q   <= pack_cor_d;
            d_valid_q    <= d_valid_d;
            d_size_q     <= d_size_d;
            d_src_q      <= d_src_d;
            err_q        <= err_d;
        end
    end

    // Beat address wraps naturally within ADDR_W.
    assign wb_addr      = (state_q == ST_DATA) ? addr_q + ADDR_W'({cnt_q, 3'b000}) : c_address;
    assign wb_data      = c_data;
    assign wb_corrupt   = c_corrupt;
    assign pack_valid   = pack_valid_q;
    assign pack_source  = pack_src_q;
    assign pack_param   = pack_param_q;
    assign pack_corrupt = pack_cor_q;
    assign d_valid      = d_valid_q;
    assign d_opcode     = 3'd6;
    assign d_param      = 3'd0;
    assign d_size       = d_size_q;
    assign d_source     = d_src_q;
    assign d_sink       = 3'(SINK_ID);
    assign err_illegal  = err_q;

endmodule

`default_nettype wire
